fir_tap_mult: RTL and testbench

//  Upstream stage of the 8-tap FIR: tap delay line plus coefficient multipliers.

---
 rtl/fir_tap_mult.sv | 110 +++++++++++
 tb/tb_fir_tap_mult.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_mult.sv
// 8-tap FIR front end: sample delay line, writable coefficients, registered per-tap products.
// Build option FIR_WARMUP_GATE_EN: hold off prod_valid until the delay line is full.

module fir_tap_lane #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int PROD_W = DATA_W + COEF_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     coef_we,
  input  logic signed [COEF_W-1:0] coef_d,
  input  logic signed [DATA_W-1:0] tap,
  input  logic                     prod_en,
  output logic        [PROD_W-1:0] prod
);
  logic signed [COEF_W-1:0] coef;
  logic signed [PROD_W-1:0] tx, cx;

  // Sign-extend both operands so the PROD_W-wide multiply is exact.
  assign tx = PROD_W'(tap);
  assign cx = PROD_W'(coef);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef <= '0;
      prod <= '0;
    end else begin
      if (coef_we) coef <= coef_d;
      if (flush)        prod <= '0;
      else if (prod_en) prod <= tx * cx;
    end
  end
endmodule

module fir_tap_mult #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic        [DATA_W-1:0]          sample_in,
  input  logic                              sample_valid,
  output logic                              sample_ready,
  input  logic                              coef_wr_en,
  input  logic        [$clog2(TAPS)-1:0]    coef_addr,
  input  logic        [COEF_W-1:0]          coef_wr_data,
  input  logic                              flush,
  output logic [(DATA_W+COEF_W)*TAPS-1:0]   prod_flat,
  output logic                              prod_valid
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int AW     = $clog2(TAPS);
  localparam int STAGES = 2;

  logic signed [DATA_W-1:0] tap [TAPS];
  logic [AW-1:0]            fill;
  logic                     accept, full, vld_in, acc_d;
  logic [STAGES:1]          vld_pipe;

  assign sample_ready = ~coef_wr_en & ~flush;
  assign accept       = sample_valid & sample_ready;

`ifdef FIR_WARMUP_GATE_EN
  // fill saturates at TAPS-1, so this accept is the TAPS-th or later.
  assign full = (fill == AW'(TAPS - 1));
`else
  assign full = 1'b1;
`endif

  assign vld_in     = accept & full;
  assign prod_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) tap[i] <= '0;
      fill     <= '0;
      acc_d    <= 1'b0;
      vld_pipe <= '0;
    end else if (flush) begin
      for (int i = 0; i < TAPS; i++) tap[i] <= '0;
      fill     <= '0;
      acc_d    <= 1'b0;
      vld_pipe <= '0;
    end else begin
      if (accept) begin
        tap[0] <= sample_in;
        for (int i = 1; i < TAPS; i++) tap[i] <= tap[i-1];
        if (fill != AW'(TAPS - 1)) fill <= fill + 1'b1;
      end
      acc_d    <= accept;
      vld_pipe <= {vld_pipe[STAGES-1:1], vld_in};
    end
  end

  for (genvar i = 0; i < TAPS; i++) begin : g_lane
    fir_tap_lane #(.DATA_W(DATA_W), .COEF_W(COEF_W), .PROD_W(PROD_W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .coef_we (coef_wr_en && (coef_addr == AW'(i))),
      .coef_d  (coef_wr_data),
      .tap     (tap[i]),
      .prod_en (acc_d),
      .prod    (prod_flat[PROD_W*(i+1)-1 -: PROD_W])
    );
  end
endmodule

// File: tb/tb_fir_tap_mult.sv
// Bench for fir_tap_mult: directed literal checks plus randomized traffic against a history-based model.
// Honours FIR_WARMUP_GATE_EN for the expected prod_valid behaviour.

module tb_fir_tap_mult;
  localparam int TAPS = 8;
  localparam int PW   = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       sample_in;
  logic              sample_valid;
  logic              sample_ready;
  logic              coef_wr_en;
  logic [2:0]        coef_addr;
  logic [15:0]       coef_wr_data;
  logic              flush;
  logic [PW*TAPS-1:0] prod_flat;
  logic              prod_valid;

  int n_chk  = 0;
  int n_fail = 0;

  fir_tap_mult #(.DATA_W(16), .COEF_W(16), .TAPS(TAPS)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .coef_wr_en(coef_wr_en), .coef_addr(coef_addr),
    .coef_wr_data(coef_wr_data), .flush(flush), .prod_flat(prod_flat),
    .prod_valid(prod_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] slot(input int i);
    logic [PW*TAPS-1:0] f;
    f = prod_flat;
    return f[PW*i +: PW];
  endfunction

  // Reference model: list of samples accepted since the last clear, newest first.
  shortint hist[$];
  int      cnt = 0;
  shortint coef_m [TAPS];
  bit      pend = 0, pend_full = 0, exp_valid = 0, zero_known = 1;
  logic [PW*TAPS-1:0] exp_prod = '0;

  always @(posedge clk) begin
    bit acc;
    if (rst) begin
      hist.delete(); cnt = 0; pend = 0; pend_full = 0;
      for (int i = 0; i < TAPS; i++) coef_m[i] = 0;
      exp_valid = 0; exp_prod = '0; zero_known = 1;
    end else begin
`ifdef FIR_WARMUP_GATE_EN
      exp_valid = pend && !flush && pend_full;
`else
      exp_valid = pend && !flush;
`endif
      if (flush) begin
        exp_prod = '0; zero_known = 1;
      end else if (pend) begin
        for (int i = 0; i < TAPS; i++) begin
          int h;
          h = (i < hist.size()) ? int'(hist[i]) : 0;
          exp_prod[PW*i +: PW] = 32'(h * int'(coef_m[i]));
        end
        zero_known = 0;
      end
      acc = sample_valid && !coef_wr_en && !flush;
      if (flush) begin hist.delete(); cnt = 0; end
      if (acc) begin
        hist.push_front(shortint'($signed(sample_in)));
        if (hist.size() > TAPS) void'(hist.pop_back());
        cnt++;
      end
      pend = acc;
      pend_full = (cnt >= TAPS);
      if (coef_wr_en && int'(coef_addr) < TAPS) coef_m[coef_addr] = shortint'($signed(coef_wr_data));
    end
    #1;
    chk("prod_valid", {31'b0, prod_valid}, {31'b0, exp_valid});
    chk("sample_ready", {31'b0, sample_ready}, {31'b0, ~coef_wr_en & ~flush});
    if (exp_valid || zero_known)
      for (int i = 0; i < TAPS; i++) chk($sformatf("prod_slot%0d", i), slot(i), exp_prod[PW*i +: PW]);
  end

  task automatic idle();
    sample_valid = 0; coef_wr_en = 0; flush = 0;
  endtask

  task automatic write_coef(input int a, input int d);
    @(negedge clk); idle(); coef_wr_en = 1; coef_addr = 3'(a); coef_wr_data = 16'(d);
    @(negedge clk); idle();
  endtask

  // Returns at the negedge where this sample's product is presented.
  task automatic send(input int s);
    @(negedge clk); idle(); sample_valid = 1; sample_in = 16'(s);
    @(negedge clk); idle();
    @(negedge clk);
  endtask

  task automatic do_flush();
    @(negedge clk); idle(); flush = 1;
    @(negedge clk); idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; idle(); sample_in = 0; coef_addr = 0; coef_wr_data = 0;
    repeat (2) @(negedge clk);
    rst = 0;

    // Reset mid-stream: in-flight sample is discarded.
    @(negedge clk); sample_valid = 1; sample_in = 16'd123;
    @(negedge clk); idle(); rst = 1;
    @(negedge clk); rst = 0; #1;
    chk("rst_valid", {31'b0, prod_valid}, 0);
    chk("rst_ready", {31'b0, sample_ready}, 1);
    chk("rst_prod_zero", {31'b0, |prod_flat}, 0);

`ifndef FIR_WARMUP_GATE_EN
    // Impulse through coef[i]=i+1.
    for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
    for (int k = 0; k < TAPS; k++) begin
      send(k == 0 ? 1 : 0);
      chk("imp_valid", {31'b0, prod_valid}, 1);
      for (int j = 0; j < TAPS; j++) chk($sformatf("imp_k%0d_s%0d", k, j), slot(j), (j == k) ? 32'(k + 1) : 32'd0);
    end
`endif

    // Signed extremes.
    do_flush();
    write_coef(0, -32768);
    send(-32768);
    chk("ext_minmin", slot(0), 32'h4000_0000);
    write_coef(0, 32767);
    send(-32768);
    chk("ext_maxmin", slot(0), 32'hC000_8000);

    // Write/stream overlap.
    do_flush();
    write_coef(0, 2);
    write_coef(1, 5);
    @(negedge clk); idle(); sample_valid = 1; sample_in = 16'd10;
    @(negedge clk); coef_wr_en = 1; coef_addr = 0; coef_wr_data = 16'd3; sample_in = 16'd99; #1;
    chk("ovl_ready", {31'b0, sample_ready}, 0);
    @(negedge clk); idle();
    chk("ovl_old_coef", slot(0), 32'd20);
    send(7);
    chk("ovl_new_coef", slot(0), 32'd21);
    chk("ovl_no_accept", slot(1), 32'd50);

    // Flush right after an accept.
    @(negedge clk); idle(); sample_valid = 1; sample_in = 16'd9;
    @(negedge clk); idle(); flush = 1;
    @(negedge clk); idle();
    chk("fl_valid", {31'b0, prod_valid}, 0);
    chk("fl_prod_zero", {31'b0, |prod_flat}, 0);
    send(4);
    chk("fl_coef_kept", slot(0), 32'd12);
    chk("fl_tap1_zero", slot(1), 32'd0);

    // Warm-up: fill counter restarts after flush.
    do_flush();
    for (int k = 1; k <= TAPS; k++) begin
      send(k);
`ifdef FIR_WARMUP_GATE_EN
      chk($sformatf("warm_%0d", k), {31'b0, prod_valid}, (k == TAPS) ? 32'd1 : 32'd0);
`else
      chk($sformatf("warm_%0d", k), {31'b0, prod_valid}, 1);
`endif
    end

    // Randomized traffic, checked by the model process.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst          = ($urandom_range(0, 199) == 0);
      sample_valid = ($urandom_range(0, 3) != 0);
      sample_in    = 16'($urandom);
      coef_wr_en   = ($urandom_range(0, 9) == 0);
      coef_addr    = 3'($urandom);
      coef_wr_data = 16'($urandom);
      flush        = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk); idle(); rst = 0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
